// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, registered
// borrow, LSB-first, with start/busy/done handshake.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             a0, b0, dbit, bo;
  logic [WIDTH-1:0] res_sh;

  // Full-subtractor cell on the current LSBs and the shifted result.
  always_comb begin
    a0     = a_q[0];
    b0     = b_q[0];
    dbit   = a0 ^ b0 ^ br_q;
    bo     = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    res_sh = res_q >> 1;
    res_sh[WIDTH-1] = dbit;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_sh;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = res_sh;
          bout_d  = bo;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign difference = diff_q;
  assign borrow     = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Randomised bench for serial_subtractor_ctrl, WIDTH=8 and WIDTH=1,
// checked against an arithmetic reference model.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       bi8 = 0;
  logic       busy8, done8, bo8;
  logic [7:0] d8;

  logic       s1 = 0, a1 = 0, b1 = 0, bi1 = 0;
  logic       busy1, done1, d1, bo1;

  serial_subtractor_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8),
    .a(a8), .b(b8), .bin(bi8),
    .busy(busy8), .done(done8),
    .difference(d8), .borrow(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1),
    .a(a1), .b(b1), .bin(bi1),
    .busy(busy1), .done(done1),
    .difference(d1), .borrow(bo1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {borrow, difference} of a - b - bin as plain arithmetic.
  function automatic logic [8:0] ref8(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic bin);
    return {1'b0, a} - {1'b0, b} - 9'(bin);
  endfunction

  function automatic logic [1:0] ref1(input logic a,
                                      input logic b,
                                      input logic bin);
    return {1'b0, a} - {1'b0, b} - 2'(bin);
  endfunction

  // Caller is at a negedge; drives a start request for the next edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b,
                        input logic bin);
    s8  = 1'b1;
    a8  = a;
    b8  = b;
    bi8 = bin;
  endtask

  // Crosses the accepting edge, scrambles inputs, waits for done.
  // Returns at the negedge inside the DONE cycle.
  task automatic wait_done(input logic [7:0] ea, input logic [7:0] eb,
                           input logic ebin, input bit poke);
    logic [8:0] r;
    logic [7:0] dh;
    logic       bh;
    int cyc, nb;
    bit stable;
    r = ref8(ea, eb, ebin);
    dh = d8;
    bh = bo8;
    cyc = 0;
    nb = 0;
    stable = 1;
    @(negedge clk);
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    bi8 = 1'($urandom);
    while (!done8 && cyc < 40) begin
      if (busy8) nb++;
      if (d8 !== dh || bo8 !== bh) stable = 0;
      s8 = (poke && cyc == 2);
      if (s8) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bi8 = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    s8 = 1'b0;
    check("latency", cyc, 8);
    check("busy_cycles", nb, 8);
    check("stable_in_run", stable, 1);
    check("busy_in_done", busy8, 0);
    check("difference", d8, r[7:0]);
    check("borrow", bo8, r[8]);
  endtask

  // One standalone op, then confirm done falls and results hold.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic bin);
    logic [8:0] r;
    r = ref8(a, b, bin);
    @(negedge clk);
    launch(a, b, bin);
    wait_done(a, b, bin, 0);
    @(negedge clk);
    check("done_one_cycle", done8, 0);
    check("diff_hold", d8, r[7:0]);
    check("borrow_hold", bo8, r[8]);
  endtask

  logic [1:0] tbl1 [8];
  logic [7:0] ra, rb;
  logic       rbi;
  bit         chain;
  bit         saw_done;

  initial begin
    tbl1 = '{2'b00, 2'b11, 2'b11, 2'b01,
             2'b10, 2'b00, 2'b00, 2'b11};

    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", d8, 0);
    check("rst_borrow", bo8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h23, 1'b0);
    check("diff_5a_23", d8, 8'h37);

    // Asynchronous reset mid-cycle clears outputs with no clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_diff", d8, 0);
    check("arst_borrow", bo8, 0);
    check("arst_busy", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h00, 8'h01, 1'b0);
    check("diff_00_01", d8, 8'hFF);
    check("bor_00_01", bo8, 1);
    run_op(8'h80, 8'h7F, 1'b1);
    check("diff_80_7f", d8, 8'h00);
    run_op(8'hFF, 8'hFF, 1'b1);
    check("diff_ff_ff", d8, 8'hFF);
    check("bor_ff_ff", bo8, 1);

    // Start pulse during RUN is ignored, then back-to-back restart.
    @(negedge clk);
    launch(8'hC3, 8'h4D, 1'b1);
    wait_done(8'hC3, 8'h4D, 1'b1, 1);
    launch(8'h10, 8'h01, 1'b0);
    wait_done(8'h10, 8'h01, 1'b0, 0);
    check("b2b_diff", d8, 8'h0F);
    @(negedge clk);
    check("b2b_done_fall", done8, 0);

    // Reset during RUN aborts with no done pulse.
    @(negedge clk);
    launch(8'hAA, 8'h11, 1'b0);
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_diff", d8, 0);
    check("abort_borrow", bo8, 0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done8) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);
    run_op(8'h05, 8'h03, 1'b0);
    check("after_abort", d8, 8'h02);

    // Random operations, some back-to-back.
    chain = 0;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbi = 1'($urandom);
      if (!chain) begin
        @(negedge clk);
        check("rnd_done_fall", done8, 0);
      end
      launch(ra, rb, rbi);
      wait_done(ra, rb, rbi, (i % 3) == 1);
      chain = 1'($urandom_range(0, 1));
    end
    @(negedge clk);

    // WIDTH=1 exhaustive truth table.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      s1 = 1'b1;
      {a1, b1, bi1} = 3'(v);
      @(negedge clk);
      s1 = 1'b0;
      check("w1_busy", {busy1, done1}, 2'b10);
      @(negedge clk);
      check("w1_done", {busy1, done1}, 2'b01);
      check("w1_table", {d1, bo1}, tbl1[v]);
      check("w1_model", {bo1, d1},
            ref1(3'(v) >> 2, (3'(v) >> 1) & 1'b1, 3'(v) & 1'b1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial multi-bit subtractor controller built around one full-subtractor cell and a registered borrow. On a start request it latches two WIDTH-bit operands and a borrow-in, then processes one bit per clock, LSB first. It returns difference and borrow-out with a start/busy/done handshake. It is the sequencing layer that turns the single-bit full subtractor into a WIDTH-bit arithmetic resource for upstream logic.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  single system clock, rising-edge active
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
bin  input  1  borrow-in; sampled on the accepting edge only
busy  output  1  high while the bit-serial operation is in progress
done  output  1  one-cycle pulse; result valid
difference  output  WIDTH  (a - b - bin) mod 2^WIDTH
borrow  output  1  final borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Clock/reset: one clock (clk); reset rst_n is asynchronous, active-low. Assertion forces state IDLE immediately, independent of clk.
- Reset values: busy=0, done=0, difference=0, borrow=0. Internal shift registers, borrow flop and bit counter are also 0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- IDLE, start=1 at edge E0: load a, b into operand shift registers and bin into the borrow flop; clear counter; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, edge Ek for k=1..WIDTH: process bit k-1.
  - d = a0 ^ b0 ^ br.
  - bo = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the internal result register from the MSB side, shift the operands right, set br <= bo, increment the counter.
- RUN exit, at edge E_WIDTH: copy the internal result register (including the bit-(WIDTH-1) d) to difference and bo to borrow in the same edge; go to DONE.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the accepting edge. With WIDTH=8, done is high after edge E8.
- DONE, start=1: accepted exactly as in IDLE (back-to-back operation, no idle bubble); go to RUN.
- DONE, start=0: go to IDLE.
- start in RUN: ignored, with no effect on the operation in progress. Changes to a/b/bin after the accepting edge are also ignored.
- difference/borrow change only at the RUN->DONE edge and hold their values until the next completion or reset. They are stable throughout RUN.
- Counter width is clog2(WIDTH)+1. No wrap occurs; the counter is cleared on accept.
- WIDTH=1: a single RUN cycle; outputs equal the full-subtractor truth table.
- Reset mid-RUN: the operation aborts with no done pulse. All outputs return to reset values, and the next start runs normally from IDLE.

Test Plan:
- Power-up/reset, WIDTH=8: drive rst_n=0 asynchronously mid-cycle -> busy=0, done=0, difference=8'h00, borrow=0 immediately, without waiting for a clk edge.
- WIDTH=8, a=8'h5A, b=8'h23, bin=0, start for 1 cycle:
  - busy=1 for 8 cycles, then done=1 for exactly 1 cycle, 8 cycles after the accepting edge.
  - Result: difference=8'h37, borrow=0; values hold after done falls.
- WIDTH=8 boundary cases:
  - a=8'h00, b=8'h01, bin=0 -> difference=8'hFF, borrow=1.
  - a=8'h80, b=8'h7F, bin=1 -> difference=8'h00, borrow=0.
  - a=8'hFF, b=8'hFF, bin=1 -> difference=8'hFF, borrow=1.
- Handshake, WIDTH=8:
  - Pulse start with new operands during RUN cycle 3 -> ignored; the first result is unchanged.
  - Hold start=1 in the DONE cycle with a=8'h10, b=8'h01, bin=0 -> second run starts with no gap; second done gives difference=8'h0F, borrow=0.
- Reset mid-operation, WIDTH=8: assert rst_n=0 in RUN cycle 4 -> no done pulse, all outputs 0. Then start a=8'h05, b=8'h03, bin=0 -> difference=8'h02, borrow=0.
- WIDTH=1, exhaustive {a,b,bin}=0..7, one start each -> (difference,borrow) = (0,0) (1,1) (1,1) (0,1) (1,0) (0,0) (0,0) (1,1). Each done is 1 cycle after its accepting edge.
